// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: fetch stage between the next-PC unit and decode.
// Owns the architectural PC, issues req/ack reads to instruction memory,
// buffers one instruction toward decode and handles flush/redirect,
// including draining a memory response that was already in flight.
// Optional feature macro: IFU_MISALIGN_TRAP_EN (misaligned-PC fetch fault).
module ifu_fetch_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      npc,
    output logic [31:0]      pc,
    input  logic             flush,
    input  logic [31:0]      flush_pc,
    output logic             im_req,
    output logic [31:0]      im_addr,
    input  logic             im_ack,
    input  logic [31:0]      im_rdata,
    output logic [31:0]      instr,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic             fetch_err,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        req_addr_q, req_addr_d;
    logic [31:0]        instr_q, instr_d;
    logic               instr_valid_q, instr_valid_d;
    logic               fetch_err_q, fetch_err_d;
    logic [CNT_W-1:0]   fetch_cnt_q, fetch_cnt_d;
    logic               misalign;

`ifdef IFU_MISALIGN_TRAP_EN
    // A misaligned PC in S_REQ is trapped locally instead of going to memory.
    assign misalign = (pc_q[1:0] != 2'b00);
    assign im_addr  = req_addr_q;
`else
    // Without the trap, misaligned addresses are silently word-aligned.
    assign misalign = 1'b0;
    assign im_addr  = req_addr_q & 32'hFFFF_FFFC;
`endif

    // Request is live while fetching or draining, never during reset.
    assign im_req = !reset &&
                    (((state_q == S_REQ) && !misalign) || (state_q == S_DRAIN));

    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign fetch_err   = fetch_err_q;
    assign fetch_cnt   = fetch_cnt_q;

    // Next-state logic; flush takes priority over everything in every state.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_addr_d    = req_addr_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        fetch_err_d   = fetch_err_q;
        fetch_cnt_d   = fetch_cnt_q;

        case (state_q)
            S_REQ: begin
                if (flush) begin
                    pc_d = flush_pc;
                    if (im_ack || misalign) begin
                        req_addr_d = flush_pc;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (misalign) begin
                    instr_d       = 32'h0;
                    instr_valid_d = 1'b1;
                    fetch_err_d   = 1'b1;
                    state_d       = S_HOLD;
                end else if (im_ack) begin
                    instr_d       = im_rdata;
                    instr_valid_d = 1'b1;
                    fetch_err_d   = 1'b0;
                    state_d       = S_HOLD;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    instr_valid_d = 1'b0;
                    fetch_err_d   = 1'b0;
                    pc_d          = flush_pc;
                    req_addr_d    = flush_pc;
                    state_d       = S_REQ;
                end else if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    fetch_err_d   = 1'b0;
                    pc_d          = npc;
                    req_addr_d    = npc;
                    fetch_cnt_d   = fetch_cnt_q + CNT_W'(1);
                    state_d       = S_REQ;
                end
            end
            S_DRAIN: begin
                if (flush) begin
                    pc_d = flush_pc;
                end
                if (im_ack) begin
                    req_addr_d = pc_d;
                    state_d    = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_REQ;
            pc_q          <= PC_RESET;
            req_addr_q    <= PC_RESET;
            instr_q       <= 32'h0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            fetch_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
            fetch_cnt_q   <= fetch_cnt_d;
        end
    end

endmodule
